// File: rtl/simeck_pkg.sv
// Shared definitions for the Simeck datapath: rotate directions, the
// supported word widths and the rotate-amount normalisation helper that the
// rotator and the key schedule both use.
package simeck_pkg;

   localparam logic ROT_LEFT  = 1'b0;
   localparam logic ROT_RIGHT = 1'b1;

   localparam int W16 = 16;
   localparam int W24 = 24;
   localparam int W32 = 32;

   // Reduce a rotate amount mod datw and express it as an equivalent left
   // rotate in [0, datw), so a right rotate by r becomes a left rotate by datw-r.
   function automatic int unsigned rot_left_amt(input int unsigned amt,
                                                input logic        dir,
                                                input int unsigned datw);
      int unsigned a;
      a = amt % datw;
      if ((dir == ROT_RIGHT) && (a != 32'd0)) begin
         a = datw - a;
      end else begin
         a = a;
      end
      return a;
   endfunction

endpackage

// File: rtl/rot_lvl.sv
// One rotator level: a registered conditional left rotate by the constant
// 2^K, selected by bit K of the normalised amount, with its own valid bit and
// elastic (bubble-collapsing) load enable.
module rot_lvl
   import simeck_pkg::*;
#(
   parameter int DATAW = W16,
   parameter int TAGW  = 4,
   parameter int LVLS  = 4,
   parameter int K     = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             up_valid,
   input  logic [DATAW-1:0] up_data,
   input  logic [LVLS-1:0]  up_amt,
   input  logic [TAGW-1:0]  up_tag,
   input  logic             dn_ready,
   output logic             dn_valid,
   output logic [DATAW-1:0] dn_data,
   output logic [LVLS-1:0]  dn_amt,
   output logic [TAGW-1:0]  dn_tag
);

   localparam int SH = 2 ** K;

   logic             valid_r;
   logic             load_s;
   logic [DATAW-1:0] rot_s;
   logic [DATAW-1:0] data_r;
   logic [LVLS-1:0]  amt_r;
   logic [TAGW-1:0]  tag_r;

   // Load enable (empty or draining) and the conditional constant rotate.
   always_comb begin
      load_s = !valid_r || dn_ready;
      if (up_amt[K]) begin
         rot_s = (up_data << SH) | (up_data >> (DATAW - SH));
      end else begin
         rot_s = up_data;
      end
   end

   // Stage register: advance when the stage can load, capture payload only on a transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_r <= 1'b0;
         data_r  <= {DATAW{1'b0}};
         amt_r   <= {LVLS{1'b0}};
         tag_r   <= {TAGW{1'b0}};
      end else if (load_s) begin
         valid_r <= up_valid;
         if (up_valid) begin
            data_r <= rot_s;
            amt_r  <= up_amt;
            tag_r  <= up_tag;
         end else begin
            data_r <= data_r;
            amt_r  <= amt_r;
            tag_r  <= tag_r;
         end
      end else begin
         valid_r <= valid_r;
      end
   end

   assign dn_valid = valid_r;
   assign dn_data  = data_r;
   assign dn_amt   = amt_r;
   assign dn_tag   = tag_r;

endmodule

// File: rtl/rot_pipe.sv
// Pipelined runtime barrel rotator: stage 0 normalises the amount/direction
// to a left rotate, then LVLS levels each apply one power-of-two rotate.
// Valid/ready flow control collapses bubbles; a tag travels with each word.
module rot_pipe
   import simeck_pkg::*;
#(
   parameter  int DATAW  = W16,
   parameter  int SHAMTW = 5,
   parameter  int TAGW   = 4,
   localparam int LVLS   = $clog2(DATAW),
   localparam int OCCW   = $clog2(LVLS + 2)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATAW-1:0]  in_data,
   input  logic [SHAMTW-1:0] in_amt,
   input  logic              in_dir,
   input  logic [TAGW-1:0]   in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATAW-1:0]  out_data,
   output logic [TAGW-1:0]   out_tag,
   output logic [OCCW-1:0]   occupancy
);

   logic [LVLS:0]    vld_s;
   logic [LVLS+1:0]  rdy_s;
   logic [LVLS:0]    vnext_s;
   logic [DATAW-1:0] d_s [0:LVLS];
   logic [LVLS-1:0]  a_s [0:LVLS];
   logic [TAGW-1:0]  t_s [0:LVLS];
   logic [LVLS-1:0]  amt_norm_s;
   logic [OCCW-1:0]  cnt_s;
   logic [OCCW-1:0]  occ_r;
   logic             v0_r;
   logic [DATAW-1:0] d0_r;
   logic [LVLS-1:0]  a0_r;
   logic [TAGW-1:0]  t0_r;
   logic             unused_amt_s;

   assign amt_norm_s = LVLS'(rot_left_amt(32'(in_amt), in_dir, DATAW));

   // Ready chain from the output back to the input: a stage accepts when empty or draining.
   always_comb begin
      logic chain;
      rdy_s = {(LVLS + 2){1'b0}};
      chain = out_ready;
      rdy_s[LVLS+1] = chain;
      for (int k = LVLS; k >= 0; k--) begin
         chain = !vld_s[k] || chain;
         rdy_s[k] = chain;
      end
   end

   // Post-edge valid bits and their population count for the occupancy register.
   always_comb begin
      vnext_s = vld_s;
      cnt_s   = {OCCW{1'b0}};
      if (rdy_s[0]) begin
         vnext_s[0] = in_valid;
      end else begin
         vnext_s[0] = vld_s[0];
      end
      for (int k = 1; k <= LVLS; k++) begin
         if (rdy_s[k]) begin
            vnext_s[k] = vld_s[k-1];
         end else begin
            vnext_s[k] = vld_s[k];
         end
      end
      for (int k = 0; k <= LVLS; k++) begin
         cnt_s = cnt_s + OCCW'(vnext_s[k]);
      end
   end

   // Stage 0: capture the word, its tag and the normalised left amount.
   always_ff @(posedge clk) begin
      if (rst) begin
         v0_r <= 1'b0;
         d0_r <= {DATAW{1'b0}};
         a0_r <= {LVLS{1'b0}};
         t0_r <= {TAGW{1'b0}};
      end else if (rdy_s[0]) begin
         v0_r <= in_valid;
         if (in_valid) begin
            d0_r <= in_data;
            a0_r <= amt_norm_s;
            t0_r <= in_tag;
         end else begin
            d0_r <= d0_r;
            a0_r <= a0_r;
            t0_r <= t0_r;
         end
      end else begin
         v0_r <= v0_r;
      end
   end

   // Occupancy register tracks the number of valid stages after each edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         occ_r <= {OCCW{1'b0}};
      end else begin
         occ_r <= cnt_s;
      end
   end

   assign vld_s[0] = v0_r;
   assign d_s[0]   = d0_r;
   assign a_s[0]   = a0_r;
   assign t_s[0]   = t0_r;

   for (genvar k = 1; k <= LVLS; k++) begin : g_lvl
      rot_lvl #(
         .DATAW (DATAW),
         .TAGW  (TAGW),
         .LVLS  (LVLS),
         .K     (k - 1)
      ) u_lvl (
         .clk      (clk),
         .rst      (rst),
         .up_valid (vld_s[k-1]),
         .up_data  (d_s[k-1]),
         .up_amt   (a_s[k-1]),
         .up_tag   (t_s[k-1]),
         .dn_ready (rdy_s[k+1]),
         .dn_valid (vld_s[k]),
         .dn_data  (d_s[k]),
         .dn_amt   (a_s[k]),
         .dn_tag   (t_s[k])
      );
   end

   // The amount is fully consumed by the last level.
   assign unused_amt_s = ^a_s[LVLS];

   assign in_ready  = rdy_s[0];
   assign out_valid = vld_s[LVLS];
   assign out_data  = d_s[LVLS];
   assign out_tag   = t_s[LVLS];
   assign occupancy = occ_r;

endmodule

// File: tb/tb_rot_pipe.sv
// Testbench for rot_pipe: directed vector table at 16 and 24 bits,
// back-pressure/ordering and reset sequences, and a randomized stream
// checked against a bit-mapping reference model with a scoreboard.
module tb_rot_pipe;

   logic        clk = 1'b0;
   logic        rst;

   logic        i16_valid, i16_ready, i16_dir, o16_valid, o16_ready;
   logic [15:0] i16_data, o16_data;
   logic [4:0]  i16_amt;
   logic [3:0]  i16_tag, o16_tag;
   logic [2:0]  occ16;

   logic        i24_valid, i24_ready, i24_dir, o24_valid, o24_ready;
   logic [23:0] i24_data, o24_data;
   logic [4:0]  i24_amt;
   logic [3:0]  i24_tag, o24_tag;
   logic [2:0]  occ24;

   int nvec  = 0;
   int nfail = 0;

   typedef struct {
      int          w;
      logic [31:0] d;
      logic [4:0]  amt;
      logic        dir;
      logic [3:0]  tag;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   rot_pipe #(.DATAW(16), .SHAMTW(5), .TAGW(4)) u16 (
      .clk(clk), .rst(rst), .in_valid(i16_valid), .in_ready(i16_ready),
      .in_data(i16_data), .in_amt(i16_amt), .in_dir(i16_dir), .in_tag(i16_tag),
      .out_valid(o16_valid), .out_ready(o16_ready), .out_data(o16_data),
      .out_tag(o16_tag), .occupancy(occ16)
   );

   rot_pipe #(.DATAW(24), .SHAMTW(5), .TAGW(4)) u24 (
      .clk(clk), .rst(rst), .in_valid(i24_valid), .in_ready(i24_ready),
      .in_data(i24_data), .in_amt(i24_amt), .in_dir(i24_dir), .in_tag(i24_tag),
      .out_valid(o24_valid), .out_ready(o24_ready), .out_data(o24_data),
      .out_tag(o24_tag), .occupancy(occ24)
   );

   // Reference: bit i of the input lands at bit (i + a) mod w, a being the
   // equivalent left amount derived from amount and direction.
   function automatic logic [31:0] ref_rot(input logic [31:0] d, input int amt,
                                           input logic dir, input int w);
      int a;
      logic [31:0] r;
      a = amt % w;
      if (dir) a = (w - a) % w;
      r = 32'h0;
      for (int i = 0; i < w; i++) r[(i + a) % w] = d[i];
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: actual %0h, required %0h", name, act, exp);
      end
   endtask

   function automatic logic get_ov(input int w);
      return (w == 16) ? o16_valid : o24_valid;
   endfunction

   task automatic add_vec(input int w, input logic [31:0] d, input logic [4:0] amt,
                          input logic dir, input logic [3:0] tag, input logic [31:0] exp);
      vec_t v;
      v.w = w; v.d = d; v.amt = amt; v.dir = dir; v.tag = tag; v.exp = exp;
      vecs.push_back(v);
   endtask

   // One word through an empty pipe: latency, data and tag.
   task automatic run_vec(input vec_t v);
      int n;
      logic ir;
      @(posedge clk); #1;
      if (v.w == 16) begin
         i16_valid = 1'b1; i16_data = v.d[15:0]; i16_amt = v.amt; i16_dir = v.dir; i16_tag = v.tag;
      end else begin
         i24_valid = 1'b1; i24_data = v.d[23:0]; i24_amt = v.amt; i24_dir = v.dir; i24_tag = v.tag;
      end
      #1;
      ir = (v.w == 16) ? i16_ready : i24_ready;
      check("vec_in_ready", 32'(ir), 32'd1);
      @(posedge clk); #1;
      i16_valid = 1'b0; i24_valid = 1'b0;
      n = 1;
      while (!get_ov(v.w) && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("vec_latency", n, (v.w == 16) ? 32'd5 : 32'd6);
      if (v.w == 16) begin
         check("vec_data16", {16'h0, o16_data}, v.exp);
         check("vec_tag16", {28'h0, o16_tag}, {28'h0, v.tag});
      end else begin
         check("vec_data24", {8'h0, o24_data}, v.exp);
         check("vec_tag24", {28'h0, o24_tag}, {28'h0, v.tag});
      end
   endtask

   initial begin
      logic [15:0] bp_d[8];
      logic [4:0]  bp_a[8];
      logic        bp_r[8];
      logic [15:0] sb_d[$];
      logic [3:0]  sb_t[$];
      int sent, got, cnt;
      logic acc, take, started, hold;
      logic [15:0] hd, ed;
      logic [3:0]  ht, et;

      rst = 1'b1;
      i16_valid = 1'b0; i16_data = 16'h0; i16_amt = 5'd0; i16_dir = 1'b0; i16_tag = 4'h0; o16_ready = 1'b1;
      i24_valid = 1'b0; i24_data = 24'h0; i24_amt = 5'd0; i24_dir = 1'b0; i24_tag = 4'h0; o24_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1; rst = 1'b0;
      #1;
      check("rst_out_valid", 32'(o16_valid), 32'd0);
      check("rst_out_data", 32'(o16_data), 32'd0);
      check("rst_out_tag", 32'(o16_tag), 32'd0);
      check("rst_occupancy", 32'(occ16), 32'd0);
      check("rst_in_ready", 32'(i16_ready), 32'd1);
      check("rst_occupancy24", 32'(occ24), 32'd0);

      // Directed vectors.
      add_vec(16, 32'h8001, 5'd5,  1'b0, 4'h3, 32'h0030);
      add_vec(16, 32'h8001, 5'd1,  1'b1, 4'h5, 32'hC000);
      add_vec(16, 32'h1234, 5'd0,  1'b0, 4'h6, 32'h1234);
      add_vec(16, 32'h1234, 5'd0,  1'b1, 4'h7, 32'h1234);
      add_vec(16, 32'h0001, 5'd17, 1'b0, 4'h8, 32'h0002);
      add_vec(16, 32'h0001, 5'd16, 1'b0, 4'h9, 32'h0001);
      add_vec(16, 32'h1234, 5'd4,  1'b0, 4'hA, 32'h2341);
      add_vec(16, 32'h1234, 5'd4,  1'b1, 4'hB, 32'h4123);
      add_vec(16, 32'h1234, 5'd31, 1'b0, 4'hC, 32'h091A);
      add_vec(24, 32'h800001, 5'd1,  1'b0, 4'h1, 32'h000003);
      add_vec(24, 32'h800001, 5'd8,  1'b1, 4'h2, 32'h018000);
      add_vec(24, 32'h800001, 5'd24, 1'b0, 4'h4, 32'h800001);
      add_vec(24, 32'h800001, 5'd25, 1'b0, 4'hD, 32'h000003);
      add_vec(24, 32'h800001, 5'd31, 1'b1, 4'hE, 32'h030000);
      for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

      // Back-pressure: fill with out_ready low, then stream out in order.
      for (int i = 0; i < 8; i++) begin
         bp_d[i] = 16'($urandom); bp_a[i] = 5'($urandom_range(0, 31)); bp_r[i] = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      o16_ready = 1'b0;
      sent = 0;
      for (int c = 0; c < 10; c++) begin
         i16_valid = (sent < 8);
         i16_data = bp_d[sent % 8]; i16_amt = bp_a[sent % 8]; i16_dir = bp_r[sent % 8]; i16_tag = 4'(sent);
         #1; acc = i16_ready && i16_valid;
         @(posedge clk); #1;
         if (acc) sent++;
      end
      check("bp_accepted", sent, 32'd5);
      check("bp_in_ready_low", 32'(i16_ready), 32'd0);
      check("bp_occupancy", 32'(occ16), 32'd5);
      check("bp_out_held_valid", 32'(o16_valid), 32'd1);
      o16_ready = 1'b1;
      got = 0; started = 1'b0;
      for (int c = 0; c < 30 && got < 8; c++) begin
         i16_valid = (sent < 8);
         i16_data = bp_d[sent % 8]; i16_amt = bp_a[sent % 8]; i16_dir = bp_r[sent % 8]; i16_tag = 4'(sent);
         #1;
         acc = i16_ready && i16_valid;
         take = o16_valid;
         if (started || take) check("bp_no_gap", 32'(take), 32'd1);
         if (take) begin
            check("bp_tag_order", 32'(o16_tag), got);
            check("bp_data", 32'(o16_data),
                  ref_rot({16'h0, bp_d[got]}, int'(bp_a[got]), bp_r[got], 16) & 32'hFFFF);
            got++;
            started = 1'b1;
         end
         @(posedge clk); #1;
         if (acc) sent++;
      end
      i16_valid = 1'b0;
      check("bp_all_out", got, 32'd8);

      // Reset with three words in flight discards them.
      for (int c = 0; c < 3; c++) begin
         i16_valid = 1'b1; i16_data = 16'($urandom); i16_amt = 5'(c); i16_dir = 1'b0; i16_tag = 4'(9 + c);
         #1; check("rstf_in_ready", 32'(i16_ready), 32'd1);
         @(posedge clk); #1;
      end
      i16_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rstf_out_valid", 32'(o16_valid), 32'd0);
      check("rstf_occupancy", 32'(occ16), 32'd0);
      check("rstf_in_ready", 32'(i16_ready), 32'd1);
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         check("rstf_no_emit", 32'(o16_valid), 32'd0);
      end

      // Randomized stream against the reference model and scoreboard.
      cnt = 0; hold = 1'b0; hd = 16'h0; ht = 4'h0;
      for (int c = 0; c < 700; c++) begin
         if (c < 620) begin
            i16_valid = ($urandom_range(0, 3) != 0);
            i16_data  = 16'($urandom);
            i16_amt   = 5'($urandom_range(0, 31));
            i16_dir   = 1'($urandom_range(0, 1));
            i16_tag   = 4'($urandom);
            o16_ready = ($urandom_range(0, 3) != 0);
         end else begin
            i16_valid = 1'b0;
            o16_ready = 1'b1;
         end
         #1;
         check("rnd_in_ready", 32'(i16_ready), 32'((cnt != 5) || o16_ready));
         if (hold) begin
            check("rnd_hold_valid", 32'(o16_valid), 32'd1);
            check("rnd_hold_data", 32'(o16_data), 32'(hd));
            check("rnd_hold_tag", 32'(o16_tag), 32'(ht));
         end
         acc  = i16_valid && i16_ready;
         take = o16_valid && o16_ready;
         if (take) begin
            if (sb_d.size() == 0) begin
               check("rnd_unexpected_out", 32'(o16_valid), 32'd0);
            end else begin
               ed = sb_d.pop_front();
               et = sb_t.pop_front();
               check("rnd_data", 32'(o16_data), 32'(ed));
               check("rnd_tag", 32'(o16_tag), 32'(et));
            end
         end
         if (acc) begin
            sb_d.push_back(16'(ref_rot({16'h0, i16_data}, int'(i16_amt), i16_dir, 16)));
            sb_t.push_back(i16_tag);
         end
         hold = o16_valid && !o16_ready;
         hd = o16_data; ht = o16_tag;
         @(posedge clk); #1;
         cnt = cnt + int'(acc) - int'(take);
         check("rnd_occupancy", 32'(occ16), cnt);
      end
      check("rnd_drained", sb_d.size(), 32'd0);
      check("rnd_final_valid", 32'(o16_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
